// File: rtl/l1_cache_nway_control.sv
// l1_cache_nway_control: N-way L1 cache control FSM (HIT / WRITE_BACK / FILL).
// Define L1_CACHE_PERF_CNT_EN to add saturating hit/miss/write-back counters.
module l1_cache_nway_control #(
    parameter int WAYS  = 4,
    parameter int CNT_W = 32,
    localparam int WB   = $clog2(WAYS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_read,
    input  logic            mem_write,
    output logic            mem_resp,
    input  logic [WAYS-1:0] hit,
    input  logic [WAYS-1:0] valid,
    input  logic [WAYS-1:0] dirty,
    input  logic [WB-1:0]   lru_way,
    output logic            l2_mem_read,
    output logic            l2_mem_write,
    input  logic            l2_mem_resp,
    output logic            l2_addr_sel,
    output logic [WB-1:0]   victim_way,
    output logic            data_in_mux_sel,
    output logic [WAYS-1:0] dirty_w,
    output logic [WAYS-1:0] valid_w,
    output logic [WAYS-1:0] tag_w,
    output logic [WAYS-1:0] data_w,
    output logic            dirty_val,
    output logic            lru_w,
    output logic [WB-1:0]   lru_upd_way,
    output logic            cache_hit,
    output logic            cache_miss
`ifdef L1_CACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
`endif
);
    typedef enum logic [1:0] {HIT, WRITE_BACK, FILL} state_t;
    state_t          r_state, w_next;
    logic [WB-1:0]   r_victim, w_hit_idx, w_inv_idx, w_victim;
    logic [WAYS-1:0] w_hit_oh, w_vic_oh;
    logic            w_req;

    // Gating the request with rst_n keeps every output at 0 while reset is held.
    assign w_req      = rst_n & (mem_read | mem_write);
    assign w_victim   = &valid ? lru_way : w_inv_idx;
    assign w_hit_oh   = WAYS'(1) << w_hit_idx;
    assign w_vic_oh   = WAYS'(1) << r_victim;
    assign victim_way = r_victim;

    // Downward scan leaves the lowest-index match in place.
    always_comb begin
        w_hit_idx = '0;
        w_inv_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit[i]) w_hit_idx = WB'(i);
            if (!valid[i]) w_inv_idx = WB'(i);
        end
    end

    always_comb begin
        w_next          = r_state;
        mem_resp        = 1'b0;
        cache_hit       = 1'b0;
        cache_miss      = 1'b0;
        lru_w           = 1'b0;
        lru_upd_way     = '0;
        l2_mem_read     = 1'b0;
        l2_mem_write    = 1'b0;
        l2_addr_sel     = 1'b0;
        data_in_mux_sel = 1'b0;
        dirty_val       = 1'b0;
        dirty_w         = '0;
        valid_w         = '0;
        tag_w           = '0;
        data_w          = '0;
        case (r_state)
            HIT: begin
                if (w_req && |hit) begin
                    mem_resp    = 1'b1;
                    cache_hit   = 1'b1;
                    lru_w       = 1'b1;
                    lru_upd_way = w_hit_idx;
                    if (mem_write) begin
                        data_in_mux_sel                  = 1'b1;
                        dirty_val                        = 1'b1;
                        {dirty_w, valid_w, tag_w, data_w} = {4{w_hit_oh}};
                    end
                end else if (w_req) begin
                    cache_miss = 1'b1;
                    w_next     = (valid[w_victim] && dirty[w_victim]) ? WRITE_BACK : FILL;
                end
            end
            WRITE_BACK: begin
                l2_mem_write = 1'b1;
                l2_addr_sel  = 1'b1;
                if (l2_mem_resp) w_next = w_req ? FILL : HIT;
            end
            FILL: begin
                l2_mem_read = 1'b1;
                if (l2_mem_resp) begin
                    w_next = HIT;
                    if (w_req) {dirty_w, valid_w, tag_w, data_w} = {4{w_vic_oh}};
                end
            end
            default: w_next = HIT;
        endcase
    end

    // Victim is latched on the miss, held through L2 traffic, cleared on return to HIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= HIT;
            r_victim <= '0;
        end else begin
            r_state  <= w_next;
            r_victim <= (w_next == HIT) ? '0 : (r_state == HIT) ? w_victim : r_victim;
        end
    end

`ifdef L1_CACHE_PERF_CNT_EN
    logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_hit_cnt, r_miss_cnt, r_wb_cnt} <= '0;
        end else begin
            if (cache_hit && !(&r_hit_cnt)) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            if (cache_miss && !(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            if (cache_miss && w_next == WRITE_BACK && !(&r_wb_cnt)) r_wb_cnt <= r_wb_cnt + CNT_W'(1);
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
    assign wb_count   = r_wb_cnt;
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = CNT_W > 0;
`endif
endmodule

// File: tb/tb_l1_cache_nway_control.sv
// tb_l1_cache_nway_control: scoreboard bench for the N-way L1 control FSM, WAYS=4 and WAYS=8.
// Counter checks are compiled in when L1_CACHE_PERF_CNT_EN is defined.
module tb_l1_cache_nway_control;
    typedef struct packed {
        logic mem_resp, l2r, l2w, l2s;
        logic [1:0] vic;
        logic dmux;
        logic [3:0] dw, vw, tw, daw;
        logic dval, lw;
        logic [1:0] lway;
        logic ch, cm;
    } o4_t;
    typedef struct packed {
        logic mem_resp, l2r, l2w, l2s;
        logic [2:0] vic;
        logic dmux;
        logic [7:0] dw, vw, tw, daw;
        logic dval, lw;
        logic [2:0] lway;
        logic ch, cm;
    } o8_t;
    typedef struct packed {logic rd, wr, resp; logic [3:0] h, v, d; logic [1:0] lru;} s4_t;
    typedef struct packed {logic rd, wr, resp; logic [7:0] h, v, d; logic [2:0] lru;} s8_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic rd = 0, wr = 0, resp = 0;
    logic [3:0] h = 0, v = 0, d = 0;
    logic [1:0] lru = 0;
    logic m4, l2r4, l2w4, l2s4, dmux4, dval4, lw4, ch4, cm4;
    logic [1:0] vic4, lway4;
    logic [3:0] dw4, vw4, tw4, daw4;

    logic rd8 = 0, wr8 = 0, resp8 = 0;
    logic [7:0] h8 = 0, v8 = 0, d8 = 0;
    logic [2:0] lru8 = 0;
    logic m8, l2r8, l2w8, l2s8, dmux8, dval8, lw8, ch8, cm8;
    logic [2:0] vic8, lway8;
    logic [7:0] dw8, vw8, tw8, daw8;

    o4_t o4;
    o8_t o8;
    assign o4 = {m4, l2r4, l2w4, l2s4, vic4, dmux4, dw4, vw4, tw4, daw4, dval4, lw4, lway4, ch4, cm4};
    assign o8 = {m8, l2r8, l2w8, l2s8, vic8, dmux8, dw8, vw8, tw8, daw8, dval8, lw8, lway8, ch8, cm8};

    int n_checks = 0;
    int n_fail = 0;
    o4_t q4[$];
    o8_t q8[$];

`ifdef L1_CACHE_PERF_CNT_EN
    logic [3:0] hc, mc, wc;
    logic [31:0] hc8, mc8, wc8;
`endif

    l1_cache_nway_control #(.WAYS(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd), .mem_write(wr), .mem_resp(m4),
        .hit(h), .valid(v), .dirty(d), .lru_way(lru),
        .l2_mem_read(l2r4), .l2_mem_write(l2w4), .l2_mem_resp(resp), .l2_addr_sel(l2s4),
        .victim_way(vic4), .data_in_mux_sel(dmux4),
        .dirty_w(dw4), .valid_w(vw4), .tag_w(tw4), .data_w(daw4), .dirty_val(dval4),
        .lru_w(lw4), .lru_upd_way(lway4), .cache_hit(ch4), .cache_miss(cm4)
`ifdef L1_CACHE_PERF_CNT_EN
        , .hit_count(hc), .miss_count(mc), .wb_count(wc)
`endif
    );

    l1_cache_nway_control #(.WAYS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd8), .mem_write(wr8), .mem_resp(m8),
        .hit(h8), .valid(v8), .dirty(d8), .lru_way(lru8),
        .l2_mem_read(l2r8), .l2_mem_write(l2w8), .l2_mem_resp(resp8), .l2_addr_sel(l2s8),
        .victim_way(vic8), .data_in_mux_sel(dmux8),
        .dirty_w(dw8), .valid_w(vw8), .tag_w(tw8), .data_w(daw8), .dirty_val(dval8),
        .lru_w(lw8), .lru_upd_way(lway8), .cache_hit(ch8), .cache_miss(cm8)
`ifdef L1_CACHE_PERF_CNT_EN
        , .hit_count(hc8), .miss_count(mc8), .wb_count(wc8)
`endif
    );

    function automatic s4_t st(logic r_, logic w_, logic p_, logic [3:0] h_, logic [3:0] v_,
                               logic [3:0] d_, logic [1:0] l_);
        return {r_, w_, p_, h_, v_, d_, l_};
    endfunction

    function automatic o4_t x_hit(logic [3:0] hv, logic w);
        o4_t e = '0;
        logic [3:0] oh = hv & (~hv + 4'd1);
        e.mem_resp = 1'b1;
        e.ch = 1'b1;
        e.lw = 1'b1;
        for (int i = 0; i < 4; i++) if (oh[i]) e.lway = 2'(i);
        if (w) begin
            e.dmux = 1'b1;
            e.dval = 1'b1;
            {e.dw, e.vw, e.tw, e.daw} = {4{oh}};
        end
        return e;
    endfunction

    function automatic o4_t x_miss();
        o4_t e = '0;
        e.cm = 1'b1;
        return e;
    endfunction

    function automatic o4_t x_l2(logic r_, logic w_, logic [1:0] vc);
        o4_t e = '0;
        e.l2r = r_;
        e.l2w = w_;
        e.l2s = w_;
        e.vic = vc;
        return e;
    endfunction

    function automatic o4_t x_fill(logic [1:0] vc);
        o4_t e = x_l2(1'b1, 1'b0, vc);
        logic [3:0] oh = 4'b0001 << vc;
        {e.dw, e.vw, e.tw, e.daw} = {4{oh}};
        return e;
    endfunction

    task automatic test_reset();
        o4_t e;
        o8_t e8;
        rst_n = 1'b0;
        {rd, wr, resp, h, v, d, lru} = st(1, 1, 1, 4'b0001, 4'b1111, 4'b1111, 2'd1);
        {rd8, wr8, resp8, h8, v8, d8, lru8} = {3'b111, 8'h01, 8'hff, 8'hff, 3'd5};
        repeat (2) @(posedge clk);
        #2;
        q4.push_back('0);
        q8.push_back('0);
        e = q4.pop_front();
        n_checks++;
        if (o4 !== e) begin n_fail++; $display("FAIL reset_outputs4: got %h want %h", o4, e); end
        e8 = q8.pop_front();
        n_checks++;
        if (o8 !== e8) begin n_fail++; $display("FAIL reset_outputs8: got %h want %h", o8, e8); end
`ifdef L1_CACHE_PERF_CNT_EN
        n_checks++;
        if ({hc, mc, wc} !== 12'h0) begin n_fail++; $display("FAIL reset_counters: got %h want 000", {hc, mc, wc}); end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        {rd, wr, resp, h, v, d, lru} = '0;
        {rd8, wr8, resp8, h8, v8, d8, lru8} = '0;
        q4.push_back('0);
        q8.push_back('0);
        @(negedge clk);
        e = q4.pop_front();
        n_checks++;
        if (o4 !== e) begin n_fail++; $display("FAIL idle4: got %h want %h", o4, e); end
        e8 = q8.pop_front();
        n_checks++;
        if (o8 !== e8) begin n_fail++; $display("FAIL idle8: got %h want %h", o8, e8); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_read_hit();
        s4_t s[$];
        o4_t x[$];
        o4_t e;
        s.push_back(st(1, 0, 0, 4'b0100, 4'b1111, 4'b0000, 2'd0)); x.push_back(x_hit(4'b0100, 0));
        s.push_back(st(1, 0, 0, 4'b0110, 4'b1111, 4'b0000, 2'd3)); x.push_back(x_hit(4'b0110, 0));
        s.push_back(st(1, 0, 0, 4'b1111, 4'b1111, 4'b1111, 2'd2)); x.push_back(x_hit(4'b1111, 0));
        s.push_back(st(0, 0, 0, 4'b0100, 4'b1111, 4'b0000, 2'd0)); x.push_back('0);
        foreach (s[i]) begin
            {rd, wr, resp, h, v, d, lru} = s[i];
            q4.push_back(x[i]);
            @(negedge clk);
            e = q4.pop_front();
            n_checks++;
            if (o4 !== e) begin n_fail++; $display("FAIL read_hit[%0d]: got %h want %h", i, o4, e); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_write_hit();
        s4_t s[$];
        o4_t x[$];
        o4_t e;
        s.push_back(st(0, 1, 0, 4'b0010, 4'b1111, 4'b0000, 2'd0)); x.push_back(x_hit(4'b0010, 1));
        s.push_back(st(1, 1, 0, 4'b1000, 4'b1111, 4'b0000, 2'd0)); x.push_back(x_hit(4'b1000, 1));
        s.push_back(st(0, 1, 0, 4'b1100, 4'b1111, 4'b1111, 2'd1)); x.push_back(x_hit(4'b1100, 1));
        s.push_back(st(0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 2'd0)); x.push_back('0);
        foreach (s[i]) begin
            {rd, wr, resp, h, v, d, lru} = s[i];
            q4.push_back(x[i]);
            @(negedge clk);
            e = q4.pop_front();
            n_checks++;
            if (o4 !== e) begin n_fail++; $display("FAIL write_hit[%0d]: got %h want %h", i, o4, e); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_write_back();
        s4_t s[$];
        o4_t x[$];
        o4_t e;
        s.push_back(st(0, 1, 0, 4'b0000, 4'b1111, 4'b1000, 2'd3)); x.push_back(x_miss());
        s.push_back(st(0, 1, 0, 4'b0000, 4'b1111, 4'b1000, 2'd3)); x.push_back(x_l2(0, 1, 2'd3));
        s.push_back(st(0, 1, 1, 4'b0000, 4'b1111, 4'b1000, 2'd3)); x.push_back(x_l2(0, 1, 2'd3));
        s.push_back(st(0, 1, 0, 4'b0000, 4'b1111, 4'b1000, 2'd3)); x.push_back(x_l2(1, 0, 2'd3));
        s.push_back(st(0, 1, 1, 4'b0000, 4'b1111, 4'b1000, 2'd3)); x.push_back(x_fill(2'd3));
        s.push_back(st(0, 1, 0, 4'b1000, 4'b1111, 4'b0000, 2'd0)); x.push_back(x_hit(4'b1000, 1));
        s.push_back(st(0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 2'd0)); x.push_back('0);
        foreach (s[i]) begin
            {rd, wr, resp, h, v, d, lru} = s[i];
            q4.push_back(x[i]);
            @(negedge clk);
            e = q4.pop_front();
            n_checks++;
            if (o4 !== e) begin n_fail++; $display("FAIL write_back[%0d]: got %h want %h", i, o4, e); end
            @(posedge clk);
            #1;
        end
`ifdef L1_CACHE_PERF_CNT_EN
        n_checks++;
        if ({hc, mc, wc} !== {4'd7, 4'd1, 4'd1}) begin
            n_fail++;
            $display("FAIL counters_after_wb: got %h want 711", {hc, mc, wc});
        end
`endif
    endtask

    task automatic test_miss_clean();
        s4_t s[$];
        o4_t x[$];
        o4_t e;
        s.push_back(st(1, 0, 0, 4'b0000, 4'b1011, 4'b0100, 2'd0)); x.push_back(x_miss());
        s.push_back(st(1, 0, 0, 4'b0000, 4'b1011, 4'b0100, 2'd0)); x.push_back(x_l2(1, 0, 2'd2));
        s.push_back(st(1, 0, 1, 4'b0000, 4'b1011, 4'b0100, 2'd0)); x.push_back(x_fill(2'd2));
        s.push_back(st(1, 0, 0, 4'b0100, 4'b1111, 4'b0000, 2'd0)); x.push_back(x_hit(4'b0100, 0));
        s.push_back(st(1, 0, 0, 4'b0000, 4'b1111, 4'b0111, 2'd3)); x.push_back(x_miss());
        s.push_back(st(1, 0, 0, 4'b0000, 4'b1111, 4'b0111, 2'd3)); x.push_back(x_l2(1, 0, 2'd3));
        s.push_back(st(0, 0, 1, 4'b0000, 4'b1111, 4'b0111, 2'd3)); x.push_back(x_l2(1, 0, 2'd3));
        s.push_back(st(0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 2'd0)); x.push_back('0);
        foreach (s[i]) begin
            {rd, wr, resp, h, v, d, lru} = s[i];
            q4.push_back(x[i]);
            @(negedge clk);
            e = q4.pop_front();
            n_checks++;
            if (o4 !== e) begin n_fail++; $display("FAIL miss_clean[%0d]: got %h want %h", i, o4, e); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_wb_drop();
        s4_t s[$];
        o4_t x[$];
        o4_t e;
        s.push_back(st(0, 1, 0, 4'b0000, 4'b1111, 4'b0010, 2'd1)); x.push_back(x_miss());
        s.push_back(st(0, 0, 0, 4'b0000, 4'b1111, 4'b0010, 2'd1)); x.push_back(x_l2(0, 1, 2'd1));
        s.push_back(st(0, 0, 1, 4'b0000, 4'b1111, 4'b0010, 2'd1)); x.push_back(x_l2(0, 1, 2'd1));
        s.push_back(st(0, 0, 0, 4'b0000, 4'b1111, 4'b0010, 2'd1)); x.push_back('0);
        foreach (s[i]) begin
            {rd, wr, resp, h, v, d, lru} = s[i];
            q4.push_back(x[i]);
            @(negedge clk);
            e = q4.pop_front();
            n_checks++;
            if (o4 !== e) begin n_fail++; $display("FAIL wb_drop[%0d]: got %h want %h", i, o4, e); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_way8();
        s8_t s[$];
        o8_t x[$];
        o8_t e;
        s.push_back({3'b100, 8'h00, 8'b11110111, 8'h00, 3'd0});
        e = '0; e.cm = 1'b1; x.push_back(e);
        s.push_back({3'b100, 8'h00, 8'b11110111, 8'h00, 3'd0});
        e = '0; e.l2r = 1'b1; e.vic = 3'd3; x.push_back(e);
        s.push_back({3'b101, 8'h00, 8'b11110111, 8'h00, 3'd0});
        e = '0; e.l2r = 1'b1; e.vic = 3'd3; {e.dw, e.vw, e.tw, e.daw} = {4{8'b00001000}}; x.push_back(e);
        s.push_back({3'b100, 8'b00001000, 8'hff, 8'h00, 3'd0});
        e = '0; e.mem_resp = 1'b1; e.ch = 1'b1; e.lw = 1'b1; e.lway = 3'd3; x.push_back(e);
        s.push_back({3'b000, 8'h00, 8'hff, 8'h00, 3'd0});
        x.push_back('0);
        foreach (s[i]) begin
            {rd8, wr8, resp8, h8, v8, d8, lru8} = s[i];
            q8.push_back(x[i]);
            @(negedge clk);
            e = q8.pop_front();
            n_checks++;
            if (o8 !== e) begin n_fail++; $display("FAIL way8[%0d]: got %h want %h", i, o8, e); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_wb();
        o4_t e;
        {rd, wr, resp, h, v, d, lru} = st(0, 1, 0, 4'b0000, 4'b1111, 4'b0010, 2'd1);
        q4.push_back(x_miss());
        @(negedge clk);
        e = q4.pop_front();
        n_checks++;
        if (o4 !== e) begin n_fail++; $display("FAIL rst_wb_miss: got %h want %h", o4, e); end
        @(posedge clk);
        #1;
        q4.push_back(x_l2(0, 1, 2'd1));
        #1;
        e = q4.pop_front();
        n_checks++;
        if (o4 !== e) begin n_fail++; $display("FAIL rst_wb_state: got %h want %h", o4, e); end
        rst_n = 1'b0;
        q4.push_back('0);
        #1;
        e = q4.pop_front();
        n_checks++;
        if (o4 !== e) begin n_fail++; $display("FAIL rst_wb_async: got %h want %h", o4, e); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        {rd, wr, resp, h, v, d, lru} = '0;
        q4.push_back('0);
        @(negedge clk);
        e = q4.pop_front();
        n_checks++;
        if (o4 !== e) begin n_fail++; $display("FAIL rst_wb_idle: got %h want %h", o4, e); end
`ifdef L1_CACHE_PERF_CNT_EN
        n_checks++;
        if ({hc, mc, wc} !== 12'h0) begin n_fail++; $display("FAIL rst_wb_counters: got %h want 000", {hc, mc, wc}); end
`endif
        @(posedge clk);
        #1;
        {rd, wr, resp, h, v, d, lru} = st(1, 0, 0, 4'b0001, 4'b1111, 4'b0000, 2'd0);
        q4.push_back(x_hit(4'b0001, 0));
        @(negedge clk);
        e = q4.pop_front();
        n_checks++;
        if (o4 !== e) begin n_fail++; $display("FAIL rst_wb_hit: got %h want %h", o4, e); end
        @(posedge clk);
        #1;
        {rd, wr, resp, h, v, d, lru} = '0;
    endtask

`ifdef L1_CACHE_PERF_CNT_EN
    task automatic test_perf_sat();
        o4_t e;
        for (int i = 0; i < 20; i++) begin
            {rd, wr, resp, h, v, d, lru} = st(1, 0, 0, 4'b0001, 4'b1111, 4'b0000, 2'd0);
            q4.push_back(x_hit(4'b0001, 0));
            @(negedge clk);
            e = q4.pop_front();
            n_checks++;
            if (o4 !== e) begin n_fail++; $display("FAIL perf_hit[%0d]: got %h want %h", i, o4, e); end
            @(posedge clk);
            #1;
        end
        {rd, wr, resp, h, v, d, lru} = '0;
        @(negedge clk);
        n_checks++;
        if ({hc, mc, wc} !== {4'd15, 4'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL perf_sat: got %h want f00", {hc, mc, wc});
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_hit();
        test_write_hit();
        test_write_back();
        test_miss_clean();
        test_wb_drop();
        test_way8();
        test_reset_mid_wb();
`ifdef L1_CACHE_PERF_CNT_EN
        test_perf_sat();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
